voting_machine_n: RTL and testbench
===================================

# voting_machine_n

Parametrised N-candidate electronic voting machine core: per-press vote qualification (debounce-by-hold, single-button rule, post-vote lockout), saturating per-candidate tallies, and a counting mode that reads out one selected tally plus running leader, tie flag and total. It is the next-generation replacement for the fixed four-candidate voting top. It sits between raw (already synchronised) candidate buttons and the display/readout logic.

## Interface

- NUM_CAND, 4, number of candidates (2..16)
- CNT_W, 8, per-candidate tally width
- HOLD_CYCLES, 4, cycles a single button must be held stable to qualify a vote (>=2)
- LOCKOUT_CYCLES, 16, cycles all buttons are ignored after an accepted vote (>=1)
- SEL_W = max(1, clog2(NUM_CAND)), derived; TOT_W = CNT_W + SEL_W, derived

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- mode  in  1  0 = voting, 1 = counting
- buttons  in  NUM_CAND  candidate buttons, bit i = candidate i, active-high
- sel  in  SEL_W  candidate index to read out in counting mode
- vote_ack  out  1  one-cycle pulse per accepted vote
- out  out  CNT_W  tally of candidate sel (counting mode), else 0
- leader  out  SEL_W  index of the highest tally (lowest index on ties)
- tie  out  1  at least two candidates share the maximum, and maximum > 0
- total  out  TOT_W  sum of all tallies
- sat  out  NUM_CAND  sticky: candidate i's tally reached all-ones

## Operation

- Qualifier FSM states: IDLE, HOLD, ACCEPT, LOCKOUT, WAIT_RELEASE. Reset -> IDLE.
- IDLE: if mode=0 and buttons is exactly one-hot, latch the index and go to HOLD with hold_cnt=1. Otherwise stay.
- HOLD: if buttons equals the latched one-hot and mode=0, increment hold_cnt. On reaching HOLD_CYCLES, go to ACCEPT. Any other pattern, or mode=1, goes to WAIT_RELEASE with no vote.
- ACCEPT (one cycle): vote_ack=1. The latched tally increments at the exiting edge. Then go to LOCKOUT. Commitment is unconditional: a mode or button change during ACCEPT does not cancel the vote.
- LOCKOUT: ignore inputs for LOCKOUT_CYCLES cycles, then go to WAIT_RELEASE.
- WAIT_RELEASE: when buttons == 0, go to IDLE. Holding a button never yields a second vote.
- Multiple buttons pressed simultaneously in IDLE: no vote, and the FSM stays in IDLE until exactly one button is pressed.
- Tallies saturate at 2^CNT_W-1. An increment at saturation leaves the tally unchanged and sets sat[i]. sat clears only on reset. vote_ack still pulses.
- Outputs are registered:
  - out = tally[sel] when mode=1, else 0. If sel >= NUM_CAND, out = 0.
  - leader, tie and total are recomputed every cycle from the tallies.
- Reset clears all tallies, sat, hold/lockout counters and every output to 0, and aborts any in-progress hold. A reset asserted during ACCEPT loses that vote.

## Timing

- A button is sampled one-hot at edge e0 (FSM in IDLE). With the pattern held, ACCEPT is entered at edge e0+HOLD_CYCLES-1.
- vote_ack is high for exactly the cycle following that edge.
- The tally updates at edge e0+HOLD_CYCLES.
- out, leader, tie and total reflect the new tally one edge later, at e0+HOLD_CYCLES+1.
- LOCKOUT occupies LOCKOUT_CYCLES cycles. The earliest next IDLE is the edge after the buttons are seen all-zero in WAIT_RELEASE.
- Minimum spacing between vote_ack pulses: HOLD_CYCLES + LOCKOUT_CYCLES + 2 cycles.
- Changes to sel or mode appear on out after 1 cycle.

## Test plan

All scenarios use NUM_CAND=4, CNT_W=4, HOLD_CYCLES=4, LOCKOUT_CYCLES=3.

- Reset, then hold buttons=4'b0010 for 10 cycles and release. Required: exactly one vote_ack, 4 cycles after first sample. Then mode=1, sel=1 -> out=1, total=1, leader=1, tie=0.
- Press 4'b0100 for 2 cycles and release (short press). Also press 4'b0011 for 8 cycles (two buttons). Required: no vote_ack, all tallies 0.
- Hold 4'b0001 continuously for 40 cycles. Required: one vote only. A second vote requires release and re-press; after that press, tally0=2.
- Cast 16 votes for candidate 3. Required:
  - tally3 = 15 after the 15th vote, with sat[3]=1.
  - After the 16th vote, tally3 stays 15 and vote_ack still pulses.
  - total=15.
- Cast 2 votes each for candidates 0 and 2. Required: tie=1, leader=0, total=4. Add 1 vote for candidate 2 -> tie=0, leader=2.
- Assert reset at the cycle vote_ack is high. Required: all tallies 0, vote_ack=0 next cycle, FSM in IDLE.
- Mid-HOLD, switch mode to 1. Required: no vote, and the FSM waits for all buttons released before accepting again.

Source files
------------

// File: rtl/voting_machine_n_if.sv
// voting_machine_n_if
// Groups the voting core's candidate-side inputs and readout-side outputs.
//   master : drives mode/buttons/sel, observes the results (button panel / readout)
//   slave  : the voting core itself
// Signals:
//   mode     - 0 = voting, 1 = counting
//   buttons  - one bit per candidate, active-high, already synchronised
//   sel      - candidate index to read out while counting
//   vote_ack - one-cycle pulse per accepted vote
//   out      - tally of candidate sel while counting, else 0
//   leader   - index of the highest tally (lowest index wins ties)
//   tie      - two or more candidates share a non-zero maximum
//   total    - sum of all tallies
//   sat      - sticky per-candidate "tally reached all-ones"
interface voting_machine_n_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
);
  localparam int SEL_W = ($clog2(NUM_CAND) < 1) ? 1 : $clog2(NUM_CAND);
  localparam int TOT_W = CNT_W + SEL_W;

  logic                mode;
  logic [NUM_CAND-1:0] buttons;
  logic [SEL_W-1:0]    sel;
  logic                vote_ack;
  logic [CNT_W-1:0]    out;
  logic [SEL_W-1:0]    leader;
  logic                tie;
  logic [TOT_W-1:0]    total;
  logic [NUM_CAND-1:0] sat;

  modport master (
    output mode, buttons, sel,
    input  vote_ack, out, leader, tie, total, sat
  );

  modport slave (
    input  mode, buttons, sel,
    output vote_ack, out, leader, tie, total, sat
  );
endinterface

// File: rtl/voting_machine_n.sv
// voting_machine_n
// N-candidate voting core. A vote counts only when exactly one button is held
// stable for HOLD_CYCLES cycles in voting mode; after each accepted vote all
// buttons are ignored for LOCKOUT_CYCLES cycles and then until every button is
// released. Tallies saturate at all-ones. All readout outputs are registered.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high; clears tallies, sat, FSM and outputs
//   bus   - voting_machine_n_if.slave (mode/buttons/sel in, results out)
module voting_machine_n #(
  parameter int NUM_CAND       = 4,
  parameter int CNT_W          = 8,
  parameter int HOLD_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES = 16
) (
  input logic               clock,
  input logic               reset,
  voting_machine_n_if.slave bus
);
  localparam int SEL_W = ($clog2(NUM_CAND) < 1) ? 1 : $clog2(NUM_CAND);
  localparam int TOT_W = CNT_W + SEL_W;
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam int LC_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    ACCEPT,
    LOCKOUT,
    WAIT_RELEASE
  } state_t;

  state_t              state, state_n;
  logic [HC_W-1:0]     hold_cnt, hold_cnt_n;
  logic [LC_W-1:0]     lock_cnt, lock_cnt_n;
  logic [NUM_CAND-1:0] held_btns, held_btns_n;
  logic [SEL_W-1:0]    cand_idx, cand_idx_n;
  logic [SEL_W-1:0]    press_idx;

  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic [NUM_CAND-1:0] sat_q;
  logic                vote_ack_q;
  logic [CNT_W-1:0]    out_q, out_c;
  logic [SEL_W-1:0]    leader_q, leader_c;
  logic                tie_q, tie_c;
  logic [TOT_W-1:0]    total_q, total_c;
  logic [CNT_W-1:0]    max_c;

  // Index of the pressed button; only meaningful when buttons is one-hot.
  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (bus.buttons[i]) press_idx = SEL_W'(i);
    end
  end

  // Qualifier next-state logic.
  always_comb begin
    state_n     = state;
    hold_cnt_n  = hold_cnt;
    lock_cnt_n  = lock_cnt;
    held_btns_n = held_btns;
    cand_idx_n  = cand_idx;
    case (state)
      IDLE: begin
        if (!bus.mode && $onehot(bus.buttons)) begin
          state_n     = HOLD;
          hold_cnt_n  = HC_W'(1);
          held_btns_n = bus.buttons;
          cand_idx_n  = press_idx;
        end
      end
      HOLD: begin
        // Any deviation from the latched press (or entering counting mode)
        // abandons the attempt and demands a full release first.
        if (!bus.mode && (bus.buttons == held_btns)) begin
          hold_cnt_n = hold_cnt + HC_W'(1);
          if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) state_n = ACCEPT;
        end else begin
          state_n = WAIT_RELEASE;
        end
      end
      ACCEPT: begin
        state_n    = LOCKOUT;
        lock_cnt_n = '0;
      end
      LOCKOUT: begin
        if (lock_cnt == LC_W'(LOCKOUT_CYCLES - 1)) state_n = WAIT_RELEASE;
        else lock_cnt_n = lock_cnt + LC_W'(1);
      end
      WAIT_RELEASE: begin
        if (bus.buttons == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Qualifier state register. vote_ack is registered from the next state so
  // it is high exactly while the FSM sits in ACCEPT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      lock_cnt   <= '0;
      held_btns  <= '0;
      cand_idx   <= '0;
      vote_ack_q <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      lock_cnt   <= lock_cnt_n;
      held_btns  <= held_btns_n;
      cand_idx   <= cand_idx_n;
      vote_ack_q <= (state_n == ACCEPT);
    end
  end

  // Leader, tie and total derived from the current tallies. Strict '>'
  // keeps the lowest index on ties.
  always_comb begin
    max_c    = '0;
    leader_c = '0;
    tie_c    = 1'b0;
    total_c  = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      total_c = total_c + TOT_W'(tally[i]);
      if (tally[i] > max_c) begin
        max_c    = tally[i];
        leader_c = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if ((max_c != '0) && (tally[i] == max_c) && (SEL_W'(i) != leader_c)) tie_c = 1'b1;
    end
  end

  // Readout mux; an out-of-range sel reads as zero.
  always_comb begin
    out_c = '0;
    if (bus.mode && (int'(bus.sel) < NUM_CAND)) out_c = tally[bus.sel];
  end

  // Tallies update on the edge leaving ACCEPT; a reset on that same edge wins
  // and the vote is lost. sat flags once a tally reaches all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
      sat_q    <= '0;
      out_q    <= '0;
      leader_q <= '0;
      tie_q    <= 1'b0;
      total_q  <= '0;
    end else begin
      if (state == ACCEPT) begin
        if (tally[cand_idx] != CNT_MAX) tally[cand_idx] <= tally[cand_idx] + CNT_W'(1);
        if (tally[cand_idx] >= CNT_MAX - CNT_W'(1)) sat_q[cand_idx] <= 1'b1;
      end
      out_q    <= out_c;
      leader_q <= leader_c;
      tie_q    <= tie_c;
      total_q  <= total_c;
    end
  end

  assign bus.vote_ack = vote_ack_q;
  assign bus.out      = out_q;
  assign bus.leader   = leader_q;
  assign bus.tie      = tie_q;
  assign bus.total    = total_q;
  assign bus.sat      = sat_q;
endmodule

// File: tb/tb_voting_machine_n.sv
// tb_voting_machine_n
// Drives press episodes (a per-cycle button/mode pattern followed by a long
// release gap) into voting_machine_n and compares against a reference that
// judges each episode as a whole: a vote is cast iff the first HOLD_CYCLES
// samples are the same one-hot pattern in voting mode. Tallies, saturation,
// leader, tie and total are then derived arithmetically from that list.
module tb_voting_machine_n;
  localparam int NC = 4;
  localparam int CW = 4;
  localparam int HC = 4;
  localparam int LC = 3;
  localparam int GAP = HC + LC + 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  voting_machine_n_if #(.NUM_CAND(NC), .CNT_W(CW)) vif ();

  voting_machine_n #(
    .NUM_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(vif.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  int m_tally [NC];
  bit m_sat   [NC];

  logic [3:0] step_btn  [64];
  bit         step_mode [64];

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clearModel();
    for (int i = 0; i < NC; i++) begin
      m_tally[i] = 0;
      m_sat[i]   = 1'b0;
    end
  endtask

  task automatic castModel(input int c);
    if (m_tally[c] < (1 << CW) - 1) m_tally[c]++;
    if (m_tally[c] == (1 << CW) - 1) m_sat[c] = 1'b1;
  endtask

  // Compare all always-visible results with the reference tallies.
  task automatic checkModel(input string tag);
    int mx, ld, cnt, tot;
    logic [3:0] s;
    mx = 0; tot = 0; ld = -1; cnt = 0;
    for (int i = 0; i < NC; i++) begin
      tot += m_tally[i];
      if (m_tally[i] > mx) mx = m_tally[i];
    end
    for (int i = 0; i < NC; i++) begin
      s[i] = m_sat[i];
      if (m_tally[i] == mx) begin
        cnt++;
        if (ld < 0) ld = i;
      end
    end
    checkOutput({tag, "_total"}, 32'(vif.total), tot);
    checkOutput({tag, "_leader"}, 32'(vif.leader), ld);
    checkOutput({tag, "_tie"}, 32'(vif.tie), 32'((cnt >= 2) && (mx > 0)));
    checkOutput({tag, "_sat"}, 32'(vif.sat), 32'(s));
    checkOutput({tag, "_out_idle"}, 32'(vif.out), 0);
  endtask

  task automatic setPress(input logic [3:0] pat, input int len);
    for (int k = 0; k < len; k++) step_btn[k] = pat;
  endtask

  // Play one episode from the step tables, checking vote_ack every cycle.
  task automatic applyStimulus(input int len, input bit rst_at_ack);
    logic [3:0] b0;
    bit vote;
    int cand;
    b0 = step_btn[0];
    vote = ($countones(b0) == 1);
    for (int k = 0; k < HC; k++) begin
      if (step_mode[k] || (step_btn[k] != b0)) vote = 1'b0;
    end
    cand = 0;
    for (int i = 0; i < NC; i++) if (b0[i]) cand = i;
    for (int k = 0; k < len + GAP; k++) begin
      @(negedge clock);
      checkOutput("vote_ack", 32'(vif.vote_ack), 32'(vote && (k == HC)));
      reset       = rst_at_ack && (k == HC);
      vif.buttons = (k < len) ? step_btn[k] : 4'b0000;
      vif.mode    = (k < len) ? step_mode[k] : 1'b0;
    end
    if (vote) begin
      if (rst_at_ack) clearModel();
      else castModel(cand);
    end
    @(negedge clock);
    checkModel("episode");
    for (int k = 0; k < 64; k++) begin
      step_btn[k]  = 4'b0000;
      step_mode[k] = 1'b0;
    end
  endtask

  task automatic pressOnce(input logic [3:0] pat, input int len);
    setPress(pat, len);
    applyStimulus(len, 1'b0);
  endtask

  // Counting-mode readout of every candidate, then back to voting mode.
  task automatic readAll();
    for (int s = 0; s < NC; s++) begin
      @(negedge clock);
      if (s > 0) checkOutput("out_sel", 32'(vif.out), m_tally[s-1]);
      vif.mode = 1'b1;
      vif.sel  = 2'(s);
    end
    @(negedge clock);
    checkOutput("out_sel", 32'(vif.out), m_tally[NC-1]);
    vif.mode = 1'b0;
    @(negedge clock);
    checkOutput("out_voting_mode", 32'(vif.out), 0);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1; vif.buttons = '0; vif.mode = 1'b0; vif.sel = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    clearModel();
    @(negedge clock);
    checkOutput("reset_vote_ack", 32'(vif.vote_ack), 0);
    checkModel("reset");
  endtask

  initial begin
    logic [3:0] pat;
    int len;
    vif.buttons = '0; vif.mode = 1'b0; vif.sel = '0;
    for (int k = 0; k < 64; k++) begin
      step_btn[k]  = 4'b0000;
      step_mode[k] = 1'b0;
    end
    clearModel();
    doReset();

    // Single held press, then counting-mode readout.
    pressOnce(4'b0010, 10);
    readAll();

    // Short press and two-button press.
    pressOnce(4'b0100, 2);
    pressOnce(4'b0011, 8);
    readAll();

    // Long hold yields one vote; a re-press yields another.
    pressOnce(4'b0001, 40);
    pressOnce(4'b0001, 5);
    readAll();

    // Saturation of candidate 3.
    doReset();
    for (int v = 0; v < 16; v++) pressOnce(4'b1000, HC);
    readAll();

    // Tie between 0 and 2, then broken in favour of 2.
    doReset();
    pressOnce(4'b0001, HC); pressOnce(4'b0001, HC);
    pressOnce(4'b0100, HC); pressOnce(4'b0100, HC);
    pressOnce(4'b0100, HC);
    readAll();

    // Reset coinciding with vote_ack loses the vote; next vote works normally.
    setPress(4'b1000, HC);
    applyStimulus(HC, 1'b1);
    pressOnce(4'b1000, HC);

    // Mode switched mid-hold, then back while the button stays down.
    setPress(4'b0100, 12);
    step_mode[2] = 1'b1;
    applyStimulus(12, 1'b0);
    pressOnce(4'b0100, HC);

    // Pattern change during hold.
    setPress(4'b0001, 2);
    for (int k = 2; k < 10; k++) step_btn[k] = 4'b0010;
    applyStimulus(10, 1'b0);

    // Randomised episodes.
    for (int e = 0; e < 30; e++) begin
      if ($urandom_range(0, 9) < 6) pat = 4'(1 << $urandom_range(0, 3));
      else pat = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 9);
      setPress(pat, len);
      if ($urandom_range(0, 4) == 0) step_mode[$urandom_range(0, len - 1)] = 1'b1;
      if ((len > 2) && ($urandom_range(0, 4) == 0)) step_btn[$urandom_range(1, len - 1)] = 4'($urandom_range(1, 15));
      applyStimulus(len, 1'b0);
      if (e % 5 == 4) readAll();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
